// File: rtl/div.sv
// Iterative radix-2 restoring divider (DIV/DIVU) producing {remainder, quotient}.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration and returns 0 after one cycle.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

`ifdef DIV_ZERO_FAST_EN
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
`else
  typedef enum logic [1:0] {FREE, ON, END} state_t;
`endif

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [64:0] rem;
  logic [31:0] divisor;
  logic        neg_q, neg_r;
  logic [64:0] shifted, rem_step;
  logic [32:0] diff;
  logic        abort;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign abort = annul_i || !start_i;

  // One restoring step: the high 33 bits hold the partial remainder, the low bits collect quotient bits.
  always_comb begin
    shifted  = {rem[63:0], 1'b0};
    diff     = shifted[64:32] - {1'b0, divisor};
    rem_step = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FREE: begin
        if (start_i && !annul_i) begin
`ifdef DIV_ZERO_FAST_EN
          state_nxt = (opdata2_i == 32'd0) ? BYZERO : ON;
`else
          state_nxt = ON;
`endif
        end
      end
`ifdef DIV_ZERO_FAST_EN
      BYZERO: state_nxt = END;
`endif
      ON: begin
        if (abort)             state_nxt = FREE;
        else if (cnt == 5'd31) state_nxt = END;
      end
      END: begin
        if (!start_i) state_nxt = FREE;
      end
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FREE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 5'd0;
      rem      <= 65'd0;
      divisor  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (start_i && !annul_i) begin
            rem     <= {33'd0, magnitude(opdata1_i, signed_div_i)};
            divisor <= magnitude(opdata2_i, signed_div_i);
            neg_q   <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_r   <= signed_div_i && opdata1_i[31];
            cnt     <= 5'd0;
          end
        end
`ifdef DIV_ZERO_FAST_EN
        BYZERO: begin
          result_o <= 64'd0;
          ready_o  <= 1'b1;
        end
`endif
        ON: begin
          if (abort) begin
            cnt      <= 5'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else begin
            rem <= rem_step;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              result_o <= {apply_sign(rem_step[63:32], neg_r), apply_sign(rem_step[31:0], neg_q)};
              ready_o  <= 1'b1;
            end
          end
        end
        END: begin
          if (!start_i) begin
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Randomized and directed bench for div, checked against an arithmetic reference model.
module tb_div;
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected {remainder, quotient} from plain arithmetic on the operands.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    longint      la, lb;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
      q = 32'd0;
      r = 32'd0;
`else
      q = 32'hFFFF_FFFF;
      r = (sgn && a[31]) ? -a : a;
      if (sgn && a[31]) begin
        q = -q;
        r = -r;
      end
`endif
    end else if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = 32'(la / lb);
      r  = 32'(la % lb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int ref_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 1;
`endif
    return 32;
  endfunction

  task automatic run(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                     input int hold, input string tag);
    logic [63:0] exp;
    int          seen;
    exp  = ref_div(sgn, a, b);
    seen = -1;
    @(posedge clk); #1;
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        seen = i;
        break;
      end
    end
    check({tag, " latency"}, 64'(seen), 64'(ref_latency(b)));
    check({tag, " result"}, result, exp);
    for (int h = 0; h < hold; h++) begin
      op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom);
      @(posedge clk); #1;
      check({tag, " hold ready"}, 64'(ready), 64'd1);
      check({tag, " hold result"}, result, exp);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, " drop ready"}, 64'(ready), 64'd0);
    check({tag, " drop result"}, result, 64'd0);
  endtask

  initial begin
    logic        rose;
    logic [31:0] a, b;
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    #12;
    check("reset ready", 64'(ready), 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clk) rst = 1'b1;

    run(0, 32'd100, 32'd7, 0, "u100_7");
    check("u100_7 literal", ref_div(0, 32'd100, 32'd7), {32'd2, 32'd14});
    run(1, -32'sd7, 32'd2, 0, "s-7_2");
    run(1, 32'd7, -32'sd2, 0, "s7_-2");
    run(0, 32'd7, 32'd0, 0, "u7_0");
    run(1, -32'sd7, 32'd0, 0, "s-7_0");
    run(1, 32'h8000_0000, 32'hFFFF_FFFF, 5, "ovf_hold");
    run(0, 32'd5, 32'd9, 1, "small");
    run(0, 32'hFFFF_FFFF, 32'd1, 0, "max_1");
    run(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "max_max");

    // Annul mid-iteration, then a fresh division.
    @(posedge clk); #1;
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    rose = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk); #1;
      rose |= ready;
    end
    annul = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rose |= ready;
    end
    start = 1'b0; annul = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      rose |= ready;
    end
    check("annul no ready", 64'(rose), 64'd0);
    check("annul result", result, 64'd0);
    run(0, 32'd9, 32'd3, 0, "after_annul");

    // Asynchronous reset mid-iteration.
    @(posedge clk); #1;
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    for (int i = 0; i <= 20; i++) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async rst ready", 64'(ready), 64'd0);
    check("async rst result", result, 64'd0);
    start = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rose |= ready;
    end
    rst = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      rose |= ready;
    end
    check("rst no ready", 64'(rose), 64'd0);
    run(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "after_rst");

    for (int n = 0; n < 25; n++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = -32'($urandom_range(1, 15));
        2:       b = 32'd0;
        default: b = $urandom;
      endcase
      run(1'($urandom), a, b, $urandom_range(0, 2), $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
